// File: rtl/selector_read_scheduler.sv
// rtl/selector_read_scheduler.sv - BRAM read and Selector window scheduler for one gridding pass
// Issues dual-port word reads per window and delays the window offset to line up with BRAM data.
module selector_read_scheduler #(
  parameter int BRAM_PARALLELISM_BITS = 4,
  parameter int BRAM_DEPTH_BITS       = 10,
  parameter int PARALLELISM           = 15,
  parameter int READ_LATENCY          = 2,
  parameter int CREDITS               = 8,
  parameter int COUNT_BITS            = 16,
  localparam int IDX_BITS  = BRAM_DEPTH_BITS + BRAM_PARALLELISM_BITS,
  localparam int CRED_BITS = $clog2(CREDITS + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [IDX_BITS-1:0]              cmd_start,
  input  logic [IDX_BITS-1:0]              cmd_stride,
  input  logic [COUNT_BITS-1:0]            cmd_count,
  output logic                             bram_en,
  output logic [BRAM_DEPTH_BITS-1:0]       bram_addr_a,
  output logic [BRAM_DEPTH_BITS-1:0]       bram_addr_b,
  output logic [BRAM_PARALLELISM_BITS-1:0] sel,
  output logic                             out_valid,
  output logic                             out_last,
  input  logic                             credit_ret,
  output logic                             busy,
  output logic                             done
);

  if (PARALLELISM > (1 << BRAM_PARALLELISM_BITS)) begin : g_bad_parallelism
    $error("PARALLELISM exceeds samples per BRAM word");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                           r_state;
  state_t                           w_next;
  logic [IDX_BITS-1:0]              r_idx;
  logic [IDX_BITS-1:0]              r_stride;
  logic [COUNT_BITS-1:0]            r_remaining;
  logic [CRED_BITS-1:0]             r_credits;
  logic                             r_bram_en;
  logic [BRAM_DEPTH_BITS-1:0]       r_addr_a;
  logic [BRAM_DEPTH_BITS-1:0]       r_addr_b;
  logic [BRAM_PARALLELISM_BITS-1:0] r_off0;
  logic                             r_last0;
  logic [READ_LATENCY-1:0]          r_pv;
  logic [READ_LATENCY-1:0]          r_pl;
  logic [BRAM_PARALLELISM_BITS-1:0] r_po [READ_LATENCY];
  logic                             r_done;

  logic                             w_accept;
  logic                             w_issue;
  logic                             w_is_last;
  logic                             w_inflight;
  logic                             w_cred_inc;
  logic                             w_cred_dec;
  logic [BRAM_DEPTH_BITS-1:0]       w_word;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_is_last  = (r_remaining == COUNT_BITS'(1));
  assign w_word     = r_idx[IDX_BITS-1:BRAM_PARALLELISM_BITS];
  assign w_cred_inc = credit_ret && !w_issue && (r_credits != CRED_BITS'(CREDITS));
  assign w_cred_dec = w_issue && !credit_ret;

  // done is registered, so DRAIN hands off while the final window still sits one
  // stage short of the output; done then lands the cycle after that window emerges.
  always_comb begin
    w_inflight = (READ_LATENCY > 1) ? r_bram_en : 1'b0;
    for (int i = 0; i < READ_LATENCY - 2; i++) begin
      w_inflight = w_inflight | r_pv[i];
    end
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = (cmd_count == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (r_credits != '0) begin
          w_issue = 1'b1;
          if (w_is_last) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_inflight) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_stride    <= '0;
      r_remaining <= '0;
      r_credits   <= CRED_BITS'(CREDITS);
      r_bram_en   <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_off0      <= '0;
      r_last0     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bram_en <= w_issue;
      r_done    <= (r_state == S_DONE);
      if (w_accept) begin
        r_idx       <= cmd_start;
        r_stride    <= cmd_stride;
        r_remaining <= cmd_count;
      end
      if (w_issue) begin
        r_addr_a    <= w_word;
        r_addr_b    <= w_word + BRAM_DEPTH_BITS'(1);
        r_off0      <= r_idx[BRAM_PARALLELISM_BITS-1:0];
        r_last0     <= w_is_last;
        r_idx       <= r_idx + r_stride;
        r_remaining <= r_remaining - COUNT_BITS'(1);
      end
      if (w_cred_dec) r_credits <= r_credits - CRED_BITS'(1);
      else if (w_cred_inc) r_credits <= r_credits + CRED_BITS'(1);
    end
  end

  // Offset/last only advance with a valid, so sel holds the last window between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      r_pl <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_po[i] <= '0;
    end else begin
      r_pv[0] <= r_bram_en;
      if (r_bram_en) begin
        r_po[0] <= r_off0;
        r_pl[0] <= r_last0;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_po[i] <= r_po[i-1];
          r_pl[i] <= r_pl[i-1];
        end
      end
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = r_done;
  assign bram_en     = r_bram_en;
  assign bram_addr_a = r_addr_a;
  assign bram_addr_b = r_addr_b;
  assign sel         = r_po[READ_LATENCY-1];
  assign out_valid   = r_pv[READ_LATENCY-1];
  assign out_last    = r_pv[READ_LATENCY-1] & r_pl[READ_LATENCY-1];

endmodule
